ksch_ctx_buffer: RTL and testbench
==================================

# ksch_ctx_buffer

Multi-context AES decryption round-key buffer. It captures forward-order round keys from a key expander into one of `NUM_CTX` key slots, with runtime key length per slot. It then replays the selected slot's schedule to the decryption engine in reverse order under a `next_rkey` pull handshake. It sits between the key expander and the decrypt core, so several keys can be held and switched per block without re-expanding.

## Interface
- `NUM_CTX`, default 2: number of key-schedule slots (≥2); `CTX_W = $clog2(NUM_CTX)` is a derived localparam.
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `wr_start` in 1: begin loading a schedule into slot `wr_ctx` with length `wr_klen`.
- `wr_ctx` in CTX_W: target slot, sampled with `wr_start`.
- `wr_klen` in 2: 00 = 128-bit key, 01 = 192-bit key, 10 = 256-bit key, 11 = reserved; sampled with `wr_start`.
- `rkey_in` in 128: round key from the expander, forward order (round 0 first).
- `rkey_vld_in` in 1: `rkey_in` is valid this cycle.
- `wr_busy` out 1: a load is in progress.
- `wr_done` out 1: one-cycle pulse when the final key of a load has been written.
- `rd_start` in 1: begin serving slot `rd_ctx`.
- `rd_ctx` in CTX_W: slot to serve, sampled with `rd_start`.
- `rkey_out` out 128: current round key, reverse order.
- `rkey_vld_out` out 1: `rkey_out` is valid.
- `rd_last` out 1: `rkey_out` is the round-0 key.
- `next_rkey` in 1: the consumer accepts `rkey_out` and requests the next key.
- `ctx_vld` out NUM_CTX: per-slot flag, complete schedule present.

## Operation
- Keys per schedule, N: 11 for 128-bit, 13 for 192-bit, 15 for 256-bit. Each slot occupies 16 entries; storage address = `{ctx, idx[3:0]}`.
- Write FSM has two states, W_IDLE and W_LOAD.
  - W_IDLE → W_LOAD on `wr_start` with `wr_klen` ≠ 11. On that transition: latch ctx and klen, set `wcnt`=0, clear `ctx_vld[wr_ctx]`, set `wr_busy`=1.
  - `wr_start` with `wr_klen`=11 is ignored; no state change.
  - In W_LOAD, each `rkey_vld_in` writes `mem[ctx][wcnt]` and increments `wcnt`.
  - When the write at `wcnt`=N-1 occurs: next cycle `ctx_vld[ctx]`=1, `klen_tab[ctx]` is updated, `wr_done`=1 for one cycle, `wr_busy`=0, FSM returns to W_IDLE.
  - `rkey_vld_in` in W_IDLE is ignored.
  - `wr_start` in W_LOAD aborts the current load. The aborted slot stays invalid, and the new load starts as from W_IDLE.
- Read FSM has two states, R_IDLE and R_RUN.
  - `rd_start` with `ctx_vld[rd_ctx]`=1: set `rptr`=N(klen_tab[rd_ctx])-1 and enter R_RUN.
  - `rd_start` on an invalid slot: go to R_IDLE with `rkey_vld_out`=0.
  - `rd_start` in R_RUN restarts the read on the new slot.
  - In R_RUN, `next_rkey` decrements `rptr`. The read address is `next_rkey ? rptr-1 : rptr` and the output is registered, so keys stream back-to-back with no bubble.
  - `rd_last`=1 when the registered key index is 0.
  - `next_rkey` while `rkey_vld_out`=0 is ignored.
  - `next_rkey` while `rd_last`=1 ends the pass; see Configuration.
- Conflicts:
  - `wr_start` targeting the slot being read aborts the read: `rkey_vld_out`=0 next cycle, FSM goes to R_IDLE.
  - `wr_start` and `rd_start` on the same slot in the same cycle: the write wins and the read does not start.
  - Because `ctx_vld` is registered, `rd_start` in the same cycle as the final write of that slot sees the slot invalid and is ignored.
  - A read and a write to the same address cannot collide, because a slot under load is always invalid.

## Timing
- Reset values: `wr_busy`=0, `wr_done`=0, `rkey_vld_out`=0, `rd_last`=0, `rkey_out`=0, `ctx_vld`=0. Both FSMs reset to idle. Storage contents are not reset.
- `rd_start` at edge t → `rkey_vld_out`=1 with key N-1 after edge t+1.
- `next_rkey` at edge t → following key on `rkey_out` after edge t+1; sustained throughput is one key per cycle.
- Last `rkey_vld_in` at edge t → `ctx_vld`/`wr_done` after edge t+1.
- `rst` low mid-operation clears everything above on the next edge. Slot contents are lost logically because `ctx_vld`=0.

## Configuration
- `KSCH_AUTO_REWIND_EN` defined: `next_rkey` with `rd_last`=1 reloads `rptr`=N-1 of the same slot. `rkey_vld_out` stays 1 and key N-1 appears next cycle, giving continuous multi-block decryption.
- Not defined: `next_rkey` with `rd_last`=1 takes the FSM to R_IDLE, `rkey_vld_out`=0 next cycle, and a new `rd_start` is required.

## Structure
- Package `aes_ksch_pkg` holds:
  - `klen_e` enum (K128, K192, K256, KRSV).
  - `RKEY_W`=128 and `SLOT_DEPTH`=16.
  - Function `num_rkeys(klen_e)` returning 11/13/15.
- One sub-module, `ksch_ram`: simple dual-port RAM, one write port and one registered read port, depth `NUM_CTX`*16, width 128, for BRAM inference.

## Test plan
- Load slot 0 with K128, 11 keys of value 0x00..00_0000+i → `wr_done` after the 11th key, `ctx_vld`=01. `rd_start` ctx 0 with `next_rkey` held high → `rkey_out` = 10, 9, …, 0 on consecutive cycles, `rd_last` on key 0.
- Load slot 1 with K256, 15 keys 0x1..._00i; read slot 1 then slot 0 → 15 keys reverse then 11 keys reverse; `klen_tab` per slot is honoured.
- `rd_start` on an unloaded slot → `rkey_vld_out` stays 0. `wr_start` with `wr_klen`=11 → `wr_busy` stays 0.
- Mid-read of slot 0 (key 6 showing), `wr_start` ctx 0 → `rkey_vld_out`=0 next cycle, `ctx_vld[0]`=0.
- `wr_start` again after 5 of 13 K192 keys, then 13 new keys → only the new data is read back, `wr_done` fires once.
- With `KSCH_AUTO_REWIND_EN`: `next_rkey` on `rd_last` → key 10 (K128) next cycle, `rkey_vld_out` stays 1. Without it → `rkey_vld_out`=0.

Source files
------------

// File: rtl/aes_ksch_pkg.sv
// aes_ksch_pkg: key-length encoding, storage sizes and schedule length helper
package aes_ksch_pkg;
  typedef enum logic [1:0] {K128 = 2'b00, K192 = 2'b01, K256 = 2'b10, KRSV = 2'b11} klen_e;
  localparam int RKEY_W = 128;
  localparam int SLOT_DEPTH = 16;
  function automatic logic [3:0] num_rkeys(klen_e k);
    return k == K256 ? 4'd15 : k == K192 ? 4'd13 : 4'd11;
  endfunction
endpackage

// File: rtl/ksch_ram.sv
// ksch_ram: simple dual-port RAM, one write port and one registered read port
module ksch_ram #(
  parameter int DEPTH = 32,
  parameter int AW = 5,
  parameter int W = 128
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/ksch_ctx_buffer.sv
// ksch_ctx_buffer: multi-slot AES round-key buffer with reverse replay; define KSCH_AUTO_REWIND_EN to rewind after the round-0 key
module ksch_ctx_buffer
  import aes_ksch_pkg::*;
#(
  parameter int NUM_CTX = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_start,
  input  logic [$clog2(NUM_CTX)-1:0] wr_ctx,
  input  logic [1:0]                 wr_klen,
  input  logic [RKEY_W-1:0]          rkey_in,
  input  logic                       rkey_vld_in,
  output logic                       wr_busy,
  output logic                       wr_done,
  input  logic                       rd_start,
  input  logic [$clog2(NUM_CTX)-1:0] rd_ctx,
  output logic [RKEY_W-1:0]          rkey_out,
  output logic                       rkey_vld_out,
  output logic                       rd_last,
  input  logic                       next_rkey,
  output logic [NUM_CTX-1:0]         ctx_vld
);
  localparam int CTX_W = $clog2(NUM_CTX);
  localparam int AW = CTX_W + 4;
  typedef enum logic {W_IDLE, W_LOAD} wstate_e;
  typedef enum logic {R_IDLE, R_RUN} rstate_e;
  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;
  logic [CTX_W-1:0] wctx_q, wctx_d, rctx_q, rctx_d;
  klen_e wklen_q, wklen_d;
  logic [3:0] wcnt_q, wcnt_d, rptr_q, rptr_d;
  logic [NUM_CTX-1:0] ctx_vld_q, ctx_vld_d;
  logic [NUM_CTX-1:0][1:0] klen_tab_q, klen_tab_d;
  logic wr_done_q, wr_done_d, we;
  logic wr_go;
  logic [RKEY_W-1:0] rdata;
  assign wr_go = wr_start && wr_klen != KRSV;
  always_comb begin
    wstate_d = wstate_q;
    wctx_d = wctx_q;
    wklen_d = wklen_q;
    wcnt_d = wcnt_q;
    ctx_vld_d = ctx_vld_q;
    klen_tab_d = klen_tab_q;
    wr_done_d = 1'b0;
    we = 1'b0;
    if (wr_go) begin
      wstate_d = W_LOAD;
      wctx_d = wr_ctx;
      wklen_d = klen_e'(wr_klen);
      wcnt_d = 4'd0;
      ctx_vld_d[wr_ctx] = 1'b0;
    end else if (wstate_q == W_LOAD && rkey_vld_in) begin
      we = 1'b1;
      wcnt_d = wcnt_q + 4'd1;
      if (wcnt_q == num_rkeys(wklen_q) - 4'd1) begin
        wstate_d = W_IDLE;
        ctx_vld_d[wctx_q] = 1'b1;
        klen_tab_d[wctx_q] = wklen_q;
        wr_done_d = 1'b1;
      end
    end
  end
  // rptr_d/rctx_d name the key shown next cycle, so they also drive the RAM read address
  always_comb begin
    rstate_d = rstate_q;
    rctx_d = rctx_q;
    rptr_d = rptr_q;
    if (rd_start) begin
      rstate_d = ctx_vld_q[rd_ctx] ? R_RUN : R_IDLE;
      rctx_d = rd_ctx;
      rptr_d = num_rkeys(klen_e'(klen_tab_q[rd_ctx])) - 4'd1;
    end else if (rstate_q == R_RUN && next_rkey) begin
`ifdef KSCH_AUTO_REWIND_EN
      rptr_d = rptr_q == 4'd0 ? num_rkeys(klen_e'(klen_tab_q[rctx_q])) - 4'd1 : rptr_q - 4'd1;
`else
      rstate_d = rptr_q == 4'd0 ? R_IDLE : R_RUN;
      rptr_d = rptr_q - 4'd1;
`endif
    end
    if (wr_go && wr_ctx == rctx_d) rstate_d = R_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      wctx_q <= '0;
      rctx_q <= '0;
      wklen_q <= K128;
      wcnt_q <= '0;
      rptr_q <= '0;
      ctx_vld_q <= '0;
      klen_tab_q <= '0;
      wr_done_q <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      wctx_q <= wctx_d;
      rctx_q <= rctx_d;
      wklen_q <= wklen_d;
      wcnt_q <= wcnt_d;
      rptr_q <= rptr_d;
      ctx_vld_q <= ctx_vld_d;
      klen_tab_q <= klen_tab_d;
      wr_done_q <= wr_done_d;
    end
  end
  ksch_ram #(.DEPTH(NUM_CTX * SLOT_DEPTH), .AW(AW), .W(RKEY_W)) u_ram (
    .clk(clk),
    .we(we),
    .waddr({wctx_q, wcnt_q}),
    .wdata(rkey_in),
    .raddr({rctx_d, rptr_d}),
    .rdata(rdata)
  );
  assign wr_busy = wstate_q == W_LOAD;
  assign wr_done = wr_done_q;
  assign rkey_vld_out = rstate_q == R_RUN;
  assign rkey_out = rkey_vld_out ? rdata : '0;
  assign rd_last = rkey_vld_out && rptr_q == 4'd0;
  assign ctx_vld = ctx_vld_q;
endmodule

// File: tb/tb_ksch_ctx_buffer.sv
// tb_ksch_ctx_buffer: directed checks of load, reverse replay, aborts and reset
module tb_ksch_ctx_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_start = 1'b0;
  logic [0:0] wr_ctx = '0;
  logic [1:0] wr_klen = '0;
  logic [127:0] rkey_in = '0;
  logic rkey_vld_in = 1'b0;
  logic wr_busy, wr_done;
  logic rd_start = 1'b0;
  logic [0:0] rd_ctx = '0;
  logic [127:0] rkey_out;
  logic rkey_vld_out, rd_last;
  logic next_rkey = 1'b0;
  logic [1:0] ctx_vld;
  int errors = 0;
  int checks = 0;
  localparam logic [127:0] BASE1 = 128'h1000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] BASE2 = 128'hdead_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] BASE3 = 128'h3000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] BASE4 = 128'h4000_0000_0000_0000_0000_0000_0000_0000;

  ksch_ctx_buffer #(.NUM_CTX(2)) dut (
    .clk(clk), .rst(rst), .wr_start(wr_start), .wr_ctx(wr_ctx), .wr_klen(wr_klen),
    .rkey_in(rkey_in), .rkey_vld_in(rkey_vld_in), .wr_busy(wr_busy), .wr_done(wr_done),
    .rd_start(rd_start), .rd_ctx(rd_ctx), .rkey_out(rkey_out), .rkey_vld_out(rkey_vld_out),
    .rd_last(rd_last), .next_rkey(next_rkey), .ctx_vld(ctx_vld)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [0:0] ctx, input logic [1:0] kl, input int n, input logic [127:0] base);
    int done_cnt;
    done_cnt = 0;
    wr_start = 1'b1; wr_ctx = ctx; wr_klen = kl; rkey_vld_in = 1'b0;
    tick();
    wr_start = 1'b0;
    check("load_busy", 128'(wr_busy), 128'(1));
    for (int i = 0; i < n; i++) begin
      rkey_in = base + 128'(i); rkey_vld_in = 1'b1;
      tick();
      done_cnt += int'(wr_done);
    end
    rkey_vld_in = 1'b0;
    check("load_done", 128'(wr_done), 128'(1));
    check("load_busy_end", 128'(wr_busy), 128'(0));
    check("load_done_cnt", 128'(done_cnt), 128'(1));
    check("load_ctx_vld", 128'(ctx_vld[ctx]), 128'(1));
    tick();
    check("load_done_pulse", 128'(wr_done), 128'(0));
  endtask

  task automatic read_all(input logic [0:0] ctx, input int n, input logic [127:0] base);
    rd_start = 1'b1; rd_ctx = ctx; next_rkey = 1'b0;
    tick();
    rd_start = 1'b0;
    next_rkey = 1'b1;
    for (int i = n - 1; i >= 0; i--) begin
      check("rd_vld", 128'(rkey_vld_out), 128'(1));
      check("rd_key", rkey_out, base + 128'(i));
      check("rd_last", 128'(rd_last), 128'(i == 0));
      tick();
    end
    next_rkey = 1'b0;
`ifdef KSCH_AUTO_REWIND_EN
    check("rewind_vld", 128'(rkey_vld_out), 128'(1));
    check("rewind_key", rkey_out, base + 128'(n - 1));
`else
    check("end_vld", 128'(rkey_vld_out), 128'(0));
`endif
  endtask

  initial begin
    int done_cnt;
    tick();
    tick();
    check("rst_busy", 128'(wr_busy), 128'(0));
    check("rst_done", 128'(wr_done), 128'(0));
    check("rst_vld", 128'(rkey_vld_out), 128'(0));
    check("rst_last", 128'(rd_last), 128'(0));
    check("rst_key", rkey_out, 128'(0));
    check("rst_ctx_vld", 128'(ctx_vld), 128'(0));
    rst = 1'b1;
    tick();
    load(1'b0, 2'b00, 11, 128'(0));
    check("ctx_vld_01", 128'(ctx_vld), 128'(2'b01));
    read_all(1'b0, 11, 128'(0));
    rd_start = 1'b1; rd_ctx = 1'b1;
    tick();
    rd_start = 1'b0;
    check("unloaded_vld", 128'(rkey_vld_out), 128'(0));
    tick();
    check("unloaded_vld2", 128'(rkey_vld_out), 128'(0));
    wr_start = 1'b1; wr_ctx = 1'b1; wr_klen = 2'b11;
    tick();
    wr_start = 1'b0;
    check("rsv_busy", 128'(wr_busy), 128'(0));
    check("rsv_ctx_vld", 128'(ctx_vld), 128'(2'b01));
    load(1'b1, 2'b10, 15, BASE1);
    check("ctx_vld_11", 128'(ctx_vld), 128'(2'b11));
    read_all(1'b1, 15, BASE1);
    read_all(1'b0, 11, 128'(0));
    rd_start = 1'b1; rd_ctx = 1'b0;
    tick();
    rd_start = 1'b0;
    next_rkey = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    next_rkey = 1'b0;
    check("mid_key6", rkey_out, 128'(6));
    wr_start = 1'b1; wr_ctx = 1'b0; wr_klen = 2'b01;
    tick();
    wr_start = 1'b0;
    check("abort_rd_vld", 128'(rkey_vld_out), 128'(0));
    check("abort_ctx_vld", 128'(ctx_vld), 128'(2'b10));
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      rkey_in = BASE2 + 128'(i); rkey_vld_in = 1'b1;
      tick();
      done_cnt += int'(wr_done);
    end
    rkey_vld_in = 1'b0;
    check("partial_no_done", 128'(done_cnt), 128'(0));
    load(1'b0, 2'b01, 13, BASE3);
    read_all(1'b0, 13, BASE3);
    rd_start = 1'b1; rd_ctx = 1'b1; wr_start = 1'b1; wr_ctx = 1'b1; wr_klen = 2'b00;
    tick();
    rd_start = 1'b0; wr_start = 1'b0;
    check("same_slot_vld", 128'(rkey_vld_out), 128'(0));
    check("same_slot_busy", 128'(wr_busy), 128'(1));
    check("same_slot_ctx_vld", 128'(ctx_vld), 128'(2'b01));
    load(1'b1, 2'b00, 11, BASE4);
    read_all(1'b1, 11, BASE4);
    rd_start = 1'b1; rd_ctx = 1'b1;
    tick();
    rd_start = 1'b0;
    check("pre_rst_vld", 128'(rkey_vld_out), 128'(1));
    rst = 1'b0;
    tick();
    check("mid_rst_vld", 128'(rkey_vld_out), 128'(0));
    check("mid_rst_ctx_vld", 128'(ctx_vld), 128'(0));
    check("mid_rst_key", rkey_out, 128'(0));
    rst = 1'b1;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
